// File: rtl/mazecaster_pkg.sv
// Shared screen geometry, RGB565 helpers and the column writer state type.
// The SHADE_EN build option (see column_pixel_writer) uses the field helpers here.
package mazecaster_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 180;

    typedef logic [15:0] rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        WAIT_SWAP
    } writer_state_t;

    function automatic logic [4:0] rgb565_r(input rgb565_t c);
        return c[15:11];
    endfunction

    function automatic logic [5:0] rgb565_g(input rgb565_t c);
        return c[10:5];
    endfunction

    function automatic logic [4:0] rgb565_b(input rgb565_t c);
        return c[4:0];
    endfunction

    function automatic rgb565_t rgb565_pack(input logic [4:0] r, input logic [5:0] g,
                                            input logic [4:0] b);
        return {r, g, b};
    endfunction

    // Row colour for a column whose wall occupies top <= y < bot.
    function automatic rgb565_t column_pixel(input logic [7:0] y, input logic [7:0] top,
                                             input logic [7:0] bot, input rgb565_t wall,
                                             input rgb565_t ceil_color,
                                             input rgb565_t floor_color);
        if (y < top)
            return ceil_color;
        else if (y < bot)
            return wall;
        else
            return floor_color;
    endfunction

endpackage

// File: rtl/rgb565_shade.sv
// Halves each RGB565 channel when side_in is set; used for the darker wall face.
module rgb565_shade
    import mazecaster_pkg::*;
(
    input  rgb565_t color_in,
    input  logic    side_in,
    output rgb565_t color_out
);

    assign color_out = side_in ? rgb565_pack(rgb565_r(color_in) >> 1,
                                             rgb565_g(color_in) >> 1,
                                             rgb565_b(color_in) >> 1)
                               : color_in;

endmodule

// File: rtl/column_pixel_writer.sv
// Expands raycast columns into RGB565 pixel writes {address, pixel}, one per cycle.
// Build option SHADE_EN: halve wall colour channels for columns with col_side_in=1.
//
// state     | meaning
// IDLE      | waiting for a column descriptor
// DRAW      | streaming rows of the current column, y_q is the row on the outputs
// WAIT_SWAP | frame complete, holding off until the frame buffers swap
module column_pixel_writer
    import mazecaster_pkg::*;
#(
    parameter rgb565_t CEIL_COLOR  = 16'h0000,
    parameter rgb565_t FLOOR_COLOR = 16'h4208
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        col_valid_in,
    output logic        col_ready_out,
    input  logic [8:0]  col_index_in,
    input  logic [7:0]  col_height_in,
    input  logic [15:0] col_color_in,
    input  logic        col_side_in,
    input  logic        col_last_in,
    input  logic        swap_in,
    output logic        ray_valid_out,
    output logic [15:0] ray_address_out,
    output logic [15:0] ray_pixel_out,
    output logic        ray_last_pixel_out
);

    localparam logic [8:0]  X_LIMIT  = 9'(SCREEN_WIDTH);
    localparam logic [7:0]  H_LIMIT  = 8'(SCREEN_HEIGHT);
    localparam logic [7:0]  LAST_ROW = 8'(SCREEN_HEIGHT - 1);
    localparam logic [15:0] ROW_STEP = 16'(SCREEN_WIDTH);

    writer_state_t state_q;
    logic [7:0]    y_q;
    logic [7:0]    top_q;
    logic [7:0]    bot_q;
    rgb565_t       color_q;
    logic          last_q;
    logic [15:0]   addr_q;

    logic          accept;
    logic          in_range;
    logic [7:0]    h_in;
    logic [7:0]    top_in;
    logic [7:0]    bot_in;
    logic [7:0]    y_next;
    rgb565_t       wall_in;

`ifdef SHADE_EN
    rgb565_shade u_shade (
        .color_in  (col_color_in),
        .side_in   (col_side_in),
        .color_out (wall_in)
    );
`else
    logic unused_side;
    assign unused_side = col_side_in;
    assign wall_in     = col_color_in;
`endif

    assign col_ready_out = (state_q == IDLE) ||
                           ((state_q == DRAW) && (y_q == LAST_ROW) && !last_q);
    assign accept        = col_valid_in && col_ready_out;
    assign in_range      = col_index_in < X_LIMIT;

    // Wall span is centred; the odd leftover row goes to the floor.
    assign h_in   = (col_height_in > H_LIMIT) ? H_LIMIT : col_height_in;
    assign top_in = (H_LIMIT - h_in) >> 1;
    assign bot_in = top_in + h_in;
    assign y_next = y_q + 8'd1;

    assign ray_address_out = addr_q;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q            <= IDLE;
            y_q                <= '0;
            top_q              <= '0;
            bot_q              <= '0;
            color_q            <= '0;
            last_q             <= 1'b0;
            addr_q             <= '0;
            ray_valid_out      <= 1'b0;
            ray_pixel_out      <= '0;
            ray_last_pixel_out <= 1'b0;
        end else begin
            ray_last_pixel_out <= 1'b0;
            if (accept) begin
                y_q     <= '0;
                top_q   <= top_in;
                bot_q   <= bot_in;
                color_q <= wall_in;
                last_q  <= col_last_in;
                addr_q  <= {7'd0, col_index_in};
                if (in_range) begin
                    state_q       <= DRAW;
                    ray_valid_out <= 1'b1;
                    ray_pixel_out <= column_pixel(8'd0, top_in, bot_in, wall_in,
                                                  CEIL_COLOR, FLOOR_COLOR);
                end else begin
                    // Off-screen column: nothing to write, but it may still close the frame.
                    ray_valid_out      <= 1'b0;
                    ray_last_pixel_out <= col_last_in;
                    state_q            <= col_last_in ? WAIT_SWAP : IDLE;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        ray_valid_out <= 1'b0;
                    end
                    DRAW: begin
                        if (y_q != LAST_ROW) begin
                            y_q                <= y_next;
                            addr_q             <= addr_q + ROW_STEP;
                            ray_valid_out      <= 1'b1;
                            ray_pixel_out      <= column_pixel(y_next, top_q, bot_q, color_q,
                                                               CEIL_COLOR, FLOOR_COLOR);
                            ray_last_pixel_out <= last_q && (y_next == LAST_ROW);
                        end else begin
                            ray_valid_out <= 1'b0;
                            state_q       <= last_q ? WAIT_SWAP : IDLE;
                        end
                    end
                    WAIT_SWAP: begin
                        ray_valid_out <= 1'b0;
                        if (swap_in)
                            state_q <= IDLE;
                    end
                    default: begin
                        ray_valid_out <= 1'b0;
                        state_q       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_column_pixel_writer.sv
// Directed and randomized checks of column_pixel_writer against a row-rule model.
module tb_column_pixel_writer;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        col_valid_in;
    logic        col_ready_out;
    logic [8:0]  col_index_in;
    logic [7:0]  col_height_in;
    logic [15:0] col_color_in;
    logic        col_side_in;
    logic        col_last_in;
    logic        swap_in;
    logic        ray_valid_out;
    logic [15:0] ray_address_out;
    logic [15:0] ray_pixel_out;
    logic        ray_last_pixel_out;

    int tests = 0;
    int fails = 0;

`ifdef SHADE_EN
    localparam bit SHADE_ON = 1'b1;
`else
    localparam bit SHADE_ON = 1'b0;
`endif

    column_pixel_writer dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst_in),
        .col_valid_in       (col_valid_in),
        .col_ready_out      (col_ready_out),
        .col_index_in       (col_index_in),
        .col_height_in      (col_height_in),
        .col_color_in       (col_color_in),
        .col_side_in        (col_side_in),
        .col_last_in        (col_last_in),
        .swap_in            (swap_in),
        .ray_valid_out      (ray_valid_out),
        .ray_address_out    (ray_address_out),
        .ray_pixel_out      (ray_pixel_out),
        .ray_last_pixel_out (ray_last_pixel_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: centred wall of min(h,180) rows, ceiling above, floor below.
    function automatic logic [15:0] exp_pixel(input int y, input int h, input logic [15:0] color,
                                              input bit side);
        int hc;
        int top;
        logic [15:0] wall;
        hc   = (h > 180) ? 180 : h;
        top  = (180 - hc) / 2;
        wall = (side && SHADE_ON) ? ((color >> 1) & 16'h7BEF) : color;
        if (y < top)      return 16'h0000;
        if (y < top + hc) return wall;
        return 16'h4208;
    endfunction

    // Called at a negedge; the column is taken on the following posedge.
    task automatic accept_col(input int x, input int h, input logic [15:0] color,
                              input bit side, input bit last);
        check("ready_before_accept", col_ready_out, 1);
        col_valid_in  = 1'b1;
        col_index_in  = 9'(x);
        col_height_in = 8'(h);
        col_color_in  = color;
        col_side_in   = side;
        col_last_in   = last;
        @(posedge clk);
        #1;
        col_valid_in = 1'b0;
        col_last_in  = 1'b0;
    endtask

    task automatic expect_col(input int x, input int h, input logic [15:0] color, input bit side,
                              input bit last, input int stop_row, input int swap_row);
        for (int y = 0; y <= stop_row; y++) begin
            @(negedge clk);
            check("row_valid", ray_valid_out, 1);
            check("row_addr", ray_address_out, 32'(x + 320 * y));
            check("row_pixel", ray_pixel_out, exp_pixel(y, h, color, side));
            check("row_last", ray_last_pixel_out, (last && y == 179) ? 1 : 0);
            check("row_ready", col_ready_out, (y == 179 && !last) ? 1 : 0);
            swap_in = (y == swap_row);
        end
        swap_in = 1'b0;
    endtask

    task automatic idle_check(input bit exp_ready);
        @(negedge clk);
        check("idle_valid", ray_valid_out, 0);
        check("idle_last", ray_last_pixel_out, 0);
        check("idle_ready", col_ready_out, exp_ready);
    endtask

    initial begin
        int x, h;
        logic [15:0] c;
        bit s;

        rst_in        = 1'b1;
        col_valid_in  = 1'b0;
        col_index_in  = '0;
        col_height_in = '0;
        col_color_in  = '0;
        col_side_in   = 1'b0;
        col_last_in   = 1'b0;
        swap_in       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", col_ready_out, 1);
        check("rst_valid", ray_valid_out, 0);
        check("rst_addr", ray_address_out, 0);
        check("rst_pixel", ray_pixel_out, 0);
        check("rst_last", ray_last_pixel_out, 0);
        rst_in = 1'b0;

        // Single column, then valid must drop after exactly 180 rows.
        accept_col(5, 60, 16'hF800, 0, 0);
        expect_col(5, 60, 16'hF800, 0, 0, 179, -1);
        idle_check(1);

        // Back-to-back columns with no bubble.
        accept_col(0, 100, 16'h07E0, 0, 0);
        expect_col(0, 100, 16'h07E0, 0, 0, 179, -1);
        accept_col(1, 100, 16'h07E0, 0, 0);
        expect_col(1, 100, 16'h07E0, 0, 0, 179, -1);
        idle_check(1);

        // Height extremes.
        accept_col(10, 0, 16'hF800, 0, 0);
        expect_col(10, 0, 16'hF800, 0, 0, 179, -1);
        idle_check(1);
        accept_col(11, 255, 16'hF800, 0, 0);
        expect_col(11, 255, 16'hF800, 0, 0, 179, -1);
        idle_check(1);

        // Shaded and unshaded faces.
        accept_col(20, 80, 16'hFFFF, 1, 0);
        expect_col(20, 80, 16'hFFFF, 1, 0, 179, -1);
        accept_col(21, 80, 16'hFFFF, 0, 0);
        expect_col(21, 80, 16'hFFFF, 0, 0, 179, -1);
        idle_check(1);

        // Stray swap while idle is ignored.
        swap_in = 1'b1;
        idle_check(1);
        swap_in = 1'b0;
        idle_check(1);

        // Random columns, some off-screen, with and without gaps.
        for (int i = 0; i < 12; i++) begin
            x = int'($urandom_range(0, 339));
            h = int'($urandom_range(0, 255));
            c = 16'($urandom);
            s = 1'($urandom);
            accept_col(x, h, c, s, 0);
            if (x >= 320) begin
                idle_check(1);
            end else begin
                expect_col(x, h, c, s, 0, 179, -1);
                if ($urandom_range(0, 1) == 1) idle_check(1);
            end
        end
        idle_check(1);

        // Off-screen final column closes the frame without a valid pixel.
        accept_col(400, 50, 16'h1234, 0, 1);
        @(negedge clk);
        check("oor_last_pulse", ray_last_pixel_out, 1);
        check("oor_last_valid", ray_valid_out, 0);
        check("oor_last_ready", col_ready_out, 0);
        idle_check(0);
        idle_check(0);
        swap_in = 1'b1;
        idle_check(1);
        swap_in = 1'b0;

        // Synchronous reset in the middle of a column.
        accept_col(7, 50, 16'h001F, 0, 0);
        expect_col(7, 50, 16'h001F, 0, 0, 90, -1);
        rst_in = 1'b1;
        @(negedge clk);
        check("midrst_valid", ray_valid_out, 0);
        check("midrst_ready", col_ready_out, 1);
        rst_in = 1'b0;
        accept_col(8, 50, 16'h001F, 0, 0);
        expect_col(8, 50, 16'h001F, 0, 0, 179, -1);
        idle_check(1);

        // Full frame with a stray swap mid-frame, then hold until swap.
        for (int col = 0; col < 320; col++) begin
            h = int'($urandom_range(0, 255));
            c = 16'($urandom);
            s = 1'($urandom);
            accept_col(col, h, c, s, col == 319);
            expect_col(col, h, c, s, col == 319, 179, (col == 100) ? 50 : -1);
        end
        for (int i = 0; i < 5; i++) idle_check(0);
        swap_in = 1'b1;
        idle_check(1);
        swap_in = 1'b0;
        idle_check(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
